// File: rtl/sample_loader8.sv
// Loads a stream of samples into eight parallel lanes that feed an 8-input adder.
// Default is block mode (FILL/FULL frames); define SAMPLE_LOADER8_SLIDING_EN for an 8-tap sliding window.
module sample_loader8 #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] n0,
    output logic [WIDTH-1:0] n1,
    output logic [WIDTH-1:0] n2,
    output logic [WIDTH-1:0] n3,
    output logic [WIDTH-1:0] n4,
    output logic [WIDTH-1:0] n5,
    output logic [WIDTH-1:0] n6,
    output logic [WIDTH-1:0] n7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       fill_cnt
);

    logic [7:0][WIDTH-1:0] lane_q, lane_d;
    logic [2:0]            fill_cnt_q, fill_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  beat;

`ifdef SAMPLE_LOADER8_SLIDING_EN

    // fill_cnt saturates at 7, so a beat arriving with fill_cnt==7 is the 8th or later sample.
    always_comb begin
        lane_d      = lane_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = out_valid_q;
        in_ready    = rst_n && (!out_valid_q || out_ready);
        beat        = in_valid && in_ready;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (beat) begin
            lane_d = {lane_q[6:0], in_data};
            if (fill_cnt_q == 3'd7) out_valid_d = 1'b1;
            else                    fill_cnt_d  = fill_cnt_q + 3'd1;
        end
    end

`else

    typedef enum logic {FILL, FULL} state_e;
    state_e state_q, state_d;

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = out_valid_q;
        in_ready    = rst_n && ((state_q == FILL) || out_ready);
        beat        = in_valid && in_ready;
        case (state_q)
            FILL: begin
                if (beat) begin
                    lane_d[fill_cnt_q] = in_data;
                    if (fill_cnt_q == 3'd7) begin
                        fill_cnt_d  = 3'd0;
                        state_d     = FULL;
                        out_valid_d = 1'b1;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 3'd1;
                    end
                end
            end
            FULL: begin
                // A beat here implies the handshake, since in_ready follows out_ready.
                if (out_ready) begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                    if (beat) begin
                        lane_d[0]  = in_data;
                        fill_cnt_d = 3'd1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q      <= '0;
            fill_cnt_q  <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign n0        = lane_q[0];
    assign n1        = lane_q[1];
    assign n2        = lane_q[2];
    assign n3        = lane_q[3];
    assign n4        = lane_q[4];
    assign n5        = lane_q[5];
    assign n6        = lane_q[6];
    assign n7        = lane_q[7];
    assign out_valid = out_valid_q;
    assign fill_cnt  = fill_cnt_q;

endmodule

// File: doc/sample_loader8.md
SAMPLE_LOADER8 -- requirements
Module: sample_loader8

Interface
REQ-001 Parameter: WIDTH, 12, sample width in bits for in_data and each lane output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  WIDTH  incoming sample.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle; beat = in_valid && in_ready.
REQ-007 n0..n7  output  WIDTH each  eight parallel lanes, registered, feeding the 8-input adder.
REQ-008 out_valid  output  1  lanes n0..n7 hold a complete frame.
REQ-009 out_ready  input  1  consumer takes the frame this cycle; frame handshake = out_valid && out_ready.
REQ-010 fill_cnt  output  3  number of lanes written in the current frame (0..7).

Function (block mode, default)
REQ-011 The block SHALL use two states: FILL and FULL.
REQ-012 In FILL, in_ready SHALL be 1; each input beat SHALL write in_data to lane n[fill_cnt] and increment fill_cnt.
REQ-013 The first sample of a frame SHALL land in n0 and the eighth in n7.
REQ-014 A beat with fill_cnt==7 SHALL write n7, wrap fill_cnt to 0, enter FULL and raise out_valid on the next cycle (latency 1 clock from the 8th beat).
REQ-015 In FULL, n0..n7 SHALL stay stable until the frame handshake.
REQ-016 In FULL, in_ready SHALL equal out_ready.
REQ-017 On a frame handshake with no input beat, the block SHALL return to FILL with out_valid=0.
REQ-018 On a frame handshake with a simultaneous input beat, the block SHALL write in_data to n0, set fill_cnt=1, clear out_valid and enter FILL in the same edge, losing no sample.
REQ-019 If out_ready is held low, the block SHALL remain in FULL indefinitely and accept no input.
REQ-020 While out_valid=0, lane values SHALL be treated as don't-care by the consumer, and the block SHALL make no stability guarantee for them.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL enter FILL and set fill_cnt=0, out_valid=0 and n0..n7=0.
REQ-022 In the reset cycle, in_ready SHALL read 0; input beats in that cycle SHALL be ignored.
REQ-023 Reset asserted mid-frame or in FULL SHALL discard the partial or held frame with no output handshake.

Configuration
REQ-024 Macro SAMPLE_LOADER8_SLIDING_EN: when defined, the block SHALL operate as an 8-tap sliding window and SHALL NOT use block mode.
REQ-025 With the macro, each input beat SHALL shift n7<=n6 ... n1<=n0 and n0<=in_data, so n0 is always the newest sample.
REQ-026 With the macro, fill_cnt SHALL saturate at 7.
REQ-027 With the macro, out_valid SHALL rise on the cycle after every beat once 8 samples have been accepted since reset, and clear on the frame handshake.
REQ-028 With the macro, in_ready SHALL equal !out_valid || out_ready.
REQ-029 Without the macro, REQ-011..REQ-020 SHALL apply unchanged, and no sliding-window logic SHALL be present.

Verification
REQ-030 Reset, then 8 beats of 0xFFF with out_ready=1 -> out_valid=1 one cycle after the 8th beat; all lanes 0xFFF; downstream adder sum 0x7FF8.
REQ-031 Beats 0x001,0xFFF alternating x8 with out_ready=0 for 5 cycles -> lanes n0=0x001, n1=0xFFF ... n7=0xFFF held stable; in_ready=0 for those 5 cycles.
REQ-032 Frame held in FULL, then out_ready=1 with in_valid=1 and in_data=0xAAA in the same cycle -> next cycle out_valid=0, n0=0xAAA, fill_cnt=1.
REQ-033 rst_n pulsed low after 5 beats of 0x7FF -> fill_cnt=0, out_valid=0, lanes 0; the next 8 beats of 0x800 form a clean frame with all lanes 0x800.
REQ-034 Continuous in_valid at 1 beat/cycle with out_ready=1 for 24 beats -> exactly 3 frames; each frame's lane order matches input order.
REQ-035 With SAMPLE_LOADER8_SLIDING_EN defined, beats 1..10 with out_ready=1 -> out_valid first rises after beat 8 (n0=8, n7=1); after beat 10, n0=10 and n7=3.
